// File: rtl/router_pkg.sv
// Shared definitions for the router output-port sink: header fields, limits, FSM states.
package router_pkg;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int MAX_LEN  = 63;

    // Router drops its FIFO contents after this many cycles without a read.
    localparam int SOFT_RST_CYCLES = 30;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_PAR,
        ST_DONE
    } sink_state_t;

    typedef struct packed {
        logic [7:0] dat;
        logic       last;
    } sink_beat_t;

endpackage

// File: rtl/router_sink_buf.sv
// 2-entry synchronous FIFO of forwarded bytes with flush and occupancy count.
// Latency: a push is visible at head the cycle after it is written.
// Backpressure: none internally; the caller never pushes into a full buffer.
module router_sink_buf
    import router_pkg::*;
(
    input  logic        clock,
    input  logic        resetn,
    input  logic        flush,
    input  logic        push,
    input  sink_beat_t  push_dat,
    input  logic        pop,
    output sink_beat_t  head,
    output logic [1:0]  count
);

    sink_beat_t mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/router_pkt_sink.sv
// Drains one router output FIFO, checks header address/parity, forwards header+payload bytes.
// Latency: s_valid 2 cycles after the header read_enb; 1 byte/cycle sustained with s_ready high.
// Backpressure: reads stop while buffered + in-flight bytes would overflow; parity read bypasses.
module router_pkt_sink
    import router_pkg::*;
#(
    parameter logic [1:0] PORT_ID = 2'd0,
    parameter int         TIMEOUT = 64
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       valid_out,
    input  logic [7:0] data_out,
    output logic       read_enb,
    output logic [7:0] s_data,
    output logic       s_valid,
    output logic       s_last,
    input  logic       s_ready,
    output logic       pkt_done,
    output logic [5:0] pkt_len,
    output logic       parity_err,
    output logic       addr_err,
    output logic       pkt_abort
);

    sink_state_t state, state_nxt;

    logic       rd_q;
    logic [6:0] req_cnt;
    logic [6:0] need;
    logic [5:0] len_q;
    logic [5:0] pay_cnt;
    logic [1:0] addr_q;
    logic [7:0] par_acc;
    logic [7:0] tmo_cnt;
    logic       active;
    logic       rd_is_par;
    logic       buf_free;
    logic       tmo_run;
    logic       timeout_hit;
    logic       cap_hdr, cap_pay, cap_par, cap_pay_last;
    logic [5:0] hdr_len;
    logic       beat_vld;
    sink_beat_t cap_beat;
    sink_beat_t out_q;
    logic       out_vld;
    logic       load_out;
    logic       buf_push, buf_pop;
    sink_beat_t buf_head;
    logic [1:0] buf_cnt;

    assign active  = (state == ST_HDR) || (state == ST_PAY) || (state == ST_PAR);
    assign hdr_len = data_out[LEN_MSB:LEN_LSB];

    // In HDR the byte after the header is always present, so it is requested before the length is known.
    assign need      = (state == ST_HDR) ? 7'd2 : ({1'b0, len_q} + 7'd2);
    assign rd_is_par = (state != ST_HDR) && (req_cnt == ({1'b0, len_q} + 7'd1));
    // The output register is a third slot, so the 2-entry buffer only has to absorb in-flight bytes.
    assign buf_free  = ({1'b0, buf_cnt} + {2'b00, rd_q}) < 3'd2;
    assign read_enb  = valid_out && active && (req_cnt < need) && (buf_free || rd_is_par);

    assign tmo_run     = active && !valid_out && !rd_q;
    assign timeout_hit = tmo_run && (tmo_cnt == 8'(TIMEOUT - 1));

    assign cap_hdr      = rd_q && (state == ST_HDR);
    assign cap_pay      = rd_q && (state == ST_PAY);
    assign cap_par      = rd_q && (state == ST_PAR);
    assign cap_pay_last = cap_pay && ((pay_cnt + 6'd1) == len_q);

    assign beat_vld      = cap_hdr || cap_pay;
    assign cap_beat.dat  = data_out;
    assign cap_beat.last = cap_hdr ? (hdr_len == 6'd0) : cap_pay_last;

    assign load_out = !out_vld || s_ready;
    assign buf_pop  = load_out && (buf_cnt != 2'd0);
    assign buf_push = beat_vld && !(load_out && (buf_cnt == 2'd0));

    router_sink_buf u_buf (
        .clock    (clock),
        .resetn   (resetn),
        .flush    (timeout_hit),
        .push     (buf_push),
        .push_dat (cap_beat),
        .pop      (buf_pop),
        .head     (buf_head),
        .count    (buf_cnt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (valid_out) state_nxt = ST_HDR;
            ST_HDR: begin
                if (timeout_hit)  state_nxt = ST_IDLE;
                else if (cap_hdr) state_nxt = (hdr_len != 6'd0) ? ST_PAY : ST_PAR;
            end
            ST_PAY: begin
                if (timeout_hit)       state_nxt = ST_IDLE;
                else if (cap_pay_last) state_nxt = ST_PAR;
            end
            ST_PAR: begin
                if (timeout_hit)  state_nxt = ST_IDLE;
                else if (cap_par) state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            rd_q       <= 1'b0;
            req_cnt    <= 7'd0;
            len_q      <= 6'd0;
            pay_cnt    <= 6'd0;
            addr_q     <= 2'd0;
            par_acc    <= 8'd0;
            tmo_cnt    <= 8'd0;
            out_q      <= '0;
            out_vld    <= 1'b0;
            pkt_len    <= 6'd0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            pkt_abort  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_q      <= read_enb;
            pkt_abort <= timeout_hit;

            if (state == ST_IDLE) begin
                req_cnt <= 7'd0;
                pay_cnt <= 6'd0;
                len_q   <= 6'd0;
            end else begin
                if (read_enb) req_cnt <= req_cnt + 7'd1;
                if (cap_pay)  pay_cnt <= pay_cnt + 6'd1;
                if (cap_hdr)  len_q   <= hdr_len;
            end

            if (cap_hdr) begin
                addr_q  <= data_out[ADDR_MSB:0];
                par_acc <= data_out;
            end else if (cap_pay) begin
                par_acc <= par_acc ^ data_out;
            end

            if (!active || read_enb) tmo_cnt <= 8'd0;
            else if (tmo_run)        tmo_cnt <= tmo_cnt + 8'd1;

            if (cap_par) begin
                pkt_len    <= len_q;
                parity_err <= (par_acc != data_out);
                addr_err   <= (addr_q != PORT_ID);
            end else if (timeout_hit) begin
                pkt_len <= len_q;
            end

            if (timeout_hit) begin
                out_vld <= 1'b0;
            end else if (load_out) begin
                if (buf_cnt != 2'd0) begin
                    out_q   <= buf_head;
                    out_vld <= 1'b1;
                end else if (beat_vld) begin
                    out_q   <= cap_beat;
                    out_vld <= 1'b1;
                end else begin
                    out_vld <= 1'b0;
                end
            end
        end
    end

    assign s_data   = out_q.dat;
    assign s_valid  = out_vld;
    assign s_last   = out_vld && out_q.last;
    assign pkt_done = (state == ST_DONE);

endmodule

// File: tb/tb_router_pkt_sink.sv
// Directed + randomized bench: router FIFO model feeds the sink, scoreboard checks stream and status.
module tb_router_pkt_sink;
    import router_pkg::*;

    localparam logic [1:0] PID = 2'd1;
    localparam int         TMO = 64;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       valid_out = 1'b0;
    logic [7:0] data_out = 8'd0;
    logic       read_enb;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready = 1'b1;
    logic       pkt_done;
    logic [5:0] pkt_len;
    logic       parity_err;
    logic       addr_err;
    logic       pkt_abort;

    router_pkt_sink #(.PORT_ID(PID), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .read_enb   (read_enb),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .pkt_done   (pkt_done),
        .pkt_len    (pkt_len),
        .parity_err (parity_err),
        .addr_err   (addr_err),
        .pkt_abort  (pkt_abort)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [7:0] rq[$];    // router FIFO contents
    logic [8:0] exq[$];   // expected {last, data} stream
    logic [7:0] stq[$];   // expected {parity_err, addr_err, len} per completed packet
    logic [7:0] pay[$];

    int cyc_n = 0;
    bit hold = 1'b0;
    bit gap_en = 1'b0;
    int rdy_mode = 0;
    int first_rd = -1;
    int acc_cyc[$];
    int abort_cyc = -1;
    int abort_cnt = 0;
    int done_cnt = 0;
    int last_cnt = 0;
    int vlow_cyc = -1;
    int rd_cnt = 0;
    int unread = 0;
    int max_unread = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample DUT at negedge, then update router model/ready just after posedge.
    task automatic cyc();
        logic       rd;
        logic       v;
        logic [8:0] e;
        logic [7:0] st;
        rd = read_enb;
        if (rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = cyc_n;
        end
        if (valid_out && !rd) begin
            unread++;
            if (unread > max_unread) max_unread = unread;
        end else begin
            unread = 0;
        end
        if (s_valid && s_ready) begin
            acc_cyc.push_back(cyc_n);
            if (s_last) last_cnt++;
            chk("stream_expected", 32'(exq.size() > 0), 32'd1);
            if (exq.size() > 0) begin
                e = exq.pop_front();
                chk("stream_byte", 32'({s_last, s_data}), 32'(e));
            end
        end
        if (pkt_done) begin
            done_cnt++;
            chk("done_expected", 32'(stq.size() > 0), 32'd1);
            if (stq.size() > 0) begin
                st = stq.pop_front();
                chk("status", 32'({parity_err, addr_err, pkt_len}), 32'(st));
            end
        end
        if (pkt_abort) begin
            abort_cnt++;
            abort_cyc = cyc_n;
        end
        @(posedge clock);
        #1;
        cyc_n++;
        if (rd && rq.size() > 0) data_out = rq.pop_front();
        hold = gap_en ? ($urandom_range(0, 3) == 0) : 1'b0;
        v = (rq.size() > 0) && !hold;
        if (valid_out && !v) vlow_cyc = cyc_n;
        valid_out = v;
        case (rdy_mode)
            0:       s_ready = 1'b1;
            1:       s_ready = ($urandom_range(0, 2) != 0);
            default: s_ready = 1'b0;
        endcase
        @(negedge clock);
    endtask

    // Queue a packet built from pay[]; n_avail < len models a packet cut short by the router.
    task automatic load_pkt(input logic [7:0] hdr, input bit bad, input int n_avail);
        int         len;
        logic [7:0] par;
        len = int'(hdr[LEN_MSB:LEN_LSB]);
        par = hdr;
        rq.push_back(hdr);
        exq.push_back({(len == 0 && n_avail >= len), hdr});
        for (int i = 0; i < len; i++) begin
            par = par ^ pay[i];
            if (i < n_avail) begin
                rq.push_back(pay[i]);
                exq.push_back({(i == len - 1), pay[i]});
            end
        end
        if (n_avail >= len) begin
            rq.push_back(par ^ {7'd0, bad});
            stq.push_back({bad, (hdr[ADDR_MSB:0] != PID), hdr[LEN_MSB:LEN_LSB]});
        end
        if (!hold) valid_out = 1'b1;
    endtask

    task automatic rand_pay(input int len);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exq.size() > 0 || stq.size() > 0) && n < 3000) begin
            cyc();
            n++;
        end
        chk(tag, 32'(n < 3000), 32'd1);
        repeat (3) cyc();
    endtask

    initial begin
        int vc;
        int n;
        int d0;
        int l0;
        int len;
        logic [7:0] hdr;

        repeat (2) @(negedge clock);
        chk("reset_outputs", 32'({read_enb, s_valid, s_last, pkt_done, pkt_abort,
                                  parity_err, addr_err, s_data, pkt_len}), 32'd0);
        resetn = 1'b1;
        repeat (3) cyc();

        // Basic packet: latency, consecutive bytes, clean status.
        pay = '{8'h11, 8'h22, 8'h33};
        first_rd = -1;
        acc_cyc.delete();
        max_unread = 0;
        vc = cyc_n;
        load_pkt(8'h0D, 1'b0, 3);
        drain("t1_drain");
        chk("t1_first_read", 32'(first_rd), 32'(vc + 1));
        chk("t1_byte_count", 32'(acc_cyc.size()), 32'd4);
        if (acc_cyc.size() >= 4) begin
            chk("t1_hdr_latency", 32'(acc_cyc[0] - first_rd), 32'd2);
            chk("t1_consecutive", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
        end
        chk("t1_status_held", 32'({parity_err, addr_err, pkt_len}), 32'({2'b00, 6'd3}));

        // Corrupted parity: same stream, parity_err flagged and held.
        pay = '{8'h11, 8'h22, 8'h33};
        load_pkt(8'h0D, 1'b1, 3);
        drain("t2_drain");
        chk("t2_parity_held", 32'(parity_err), 32'd1);

        // Zero-length packet to the wrong port.
        pay.delete();
        load_pkt(8'h02, 1'b0, 0);
        drain("t3_drain");
        chk("t3_addr_err", 32'({parity_err, addr_err, pkt_len}), 32'({2'b01, 6'd0}));
        chk("t3_read_within_2", 32'(max_unread <= 2), 32'd1);

        // Downstream stall: header held on s_data, only two more bytes fetched.
        rand_pay(10);
        rdy_mode = 2;
        s_ready = 1'b0;
        rd_cnt = 0;
        max_unread = 0;
        acc_cyc.delete();
        load_pkt({6'd10, PID}, 1'b0, 10);
        n = 0;
        while (!s_valid && n < 20) begin
            cyc();
            n++;
        end
        chk("t4_hdr_shown", 32'(s_valid), 32'd1);
        repeat (8) cyc();
        chk("t4_reads_stalled", 32'(rd_cnt), 32'd3);
        chk("t4_read_idle", 32'(read_enb), 32'd0);
        chk("t4_under_soft_rst", 32'(max_unread < SOFT_RST_CYCLES), 32'd1);
        rdy_mode = 0;
        s_ready = 1'b1;
        drain("t4_drain");
        chk("t4_byte_count", 32'(acc_cyc.size()), 32'd11);
        if (acc_cyc.size() == 11) chk("t4_resume_rate", 32'(acc_cyc[10] - acc_cyc[0]), 32'd10);

        // Timeout abort: router stops after 2 of 5 payload bytes.
        rand_pay(5);
        abort_cnt = 0;
        d0 = done_cnt;
        l0 = last_cnt;
        vlow_cyc = -1;
        load_pkt(8'h15, 1'b0, 2);
        n = 0;
        while (abort_cnt == 0 && n < 300) begin
            cyc();
            n++;
        end
        chk("t5_abort_seen", 32'(abort_cnt), 32'd1);
        chk("t5_abort_latency", 32'((abort_cyc - vlow_cyc >= TMO) && (abort_cyc - vlow_cyc <= TMO + 2)), 32'd1);
        chk("t5_pkt_len", 32'(pkt_len), 32'd5);
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_no_last", 32'(last_cnt - l0), 32'd0);
        chk("t5_partial_forwarded", 32'(exq.size()), 32'd0);
        cyc();
        chk("t5_flushed", 32'({s_valid, pkt_abort}), 32'd0);
        rq.delete();
        exq.delete();
        rand_pay(7);
        load_pkt({6'd7, PID}, 1'b0, 7);
        drain("t6_after_abort");
        chk("t6_status", 32'({parity_err, addr_err, pkt_len}), 32'({2'b00, 6'd7}));

        // Asynchronous reset mid-payload.
        rand_pay(20);
        load_pkt({6'd20, PID}, 1'b0, 20);
        repeat (8) cyc();
        resetn = 1'b0;
        #1;
        chk("t7_reset_outputs", 32'({read_enb, s_valid, s_last, pkt_done, pkt_abort,
                                     parity_err, addr_err, s_data, pkt_len}), 32'd0);
        rq.delete();
        exq.delete();
        stq.delete();
        valid_out = 1'b0;
        data_out = 8'd0;
        cyc();
        resetn = 1'b1;
        cyc();
        rand_pay(4);
        load_pkt({6'd4, PID}, 1'b1, 4);
        drain("t7_after_reset");

        // Randomized packets with input gaps and random downstream ready.
        gap_en = 1'b1;
        rdy_mode = 1;
        for (int p = 0; p < 14; p++) begin
            len = (p == 5) ? MAX_LEN : int'($urandom_range(0, 24));
            hdr = {6'(len), 2'($urandom_range(0, 3))};
            rand_pay(len);
            load_pkt(hdr, 1'($urandom_range(0, 1)), len);
            drain("rand_drain");
        end
        gap_en = 1'b0;
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
